// File: rtl/isqrt_exec_unit.sv
// Multi-cycle unsigned integer square root: floor root, remainder and tag are
// handed to writeback over a valid/ready pair; flush squashes the operation.
//   state | meaning
//   IDLE  | ready to accept a radicand
//   CALC  | resolving ITER_PER_CYC radicand bit-pairs per clock
//   DONE  | result registered and offered to writeback
module isqrt_exec_unit #(
  parameter int DATA_W       = 32,
  parameter int TAG_W        = 5,
  parameter int ITER_PER_CYC = 1
) (
  input  logic                clk1,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_radicand,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W/2-1:0] out_root,
  output logic [DATA_W/2:0]   out_rem,
  output logic [TAG_W-1:0]    out_tag,
  output logic                busy
);

  localparam int RW    = DATA_W / 2;
  localparam int EW    = RW + 3;
  localparam int NITER = DATA_W / (2 * ITER_PER_CYC);
  localparam int CW    = $clog2(NITER + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] rad_q, rad_d;
  logic [RW-1:0]     root_q, root_d;
  logic [RW:0]       rem_q, rem_d;
  logic [TAG_W-1:0]  tag_q;
  logic [EW-1:0]     acc, trial;
  logic              accept, finish;

  // The shifted remainder can reach 8*root+3 before the subtract, hence the
  // two extra guard bits on the working accumulator.
  always_comb begin
    acc    = EW'(rem_q);
    root_d = root_q;
    rad_d  = rad_q;
    trial  = '0;
    for (int i = 0; i < ITER_PER_CYC; i++) begin
      acc   = (acc << 2) | EW'(rad_d[DATA_W-1 -: 2]);
      rad_d = rad_d << 2;
      trial = EW'({root_d, 2'b01});
      if (acc >= trial) begin
        acc    = acc - trial;
        root_d = {root_d[RW-2:0], 1'b1};
      end else begin
        root_d = {root_d[RW-2:0], 1'b0};
      end
    end
    rem_d = acc[RW:0];
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush && in_valid) begin
          accept  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(1)) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (flush || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rad_q    <= '0;
      root_q   <= '0;
      rem_q    <= '0;
      tag_q    <= '0;
      out_root <= '0;
      out_rem  <= '0;
      out_tag  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rad_q  <= in_radicand;
        tag_q  <= in_tag;
        root_q <= '0;
        rem_q  <= '0;
        cnt_q  <= CW'(NITER);
      end else if (state_q == CALC && !flush) begin
        rad_q  <= rad_d;
        root_q <= root_d;
        rem_q  <= rem_d;
        cnt_q  <= cnt_q - CW'(1);
      end
      if (finish) begin
        out_root <= root_d;
        out_rem  <= rem_d;
        out_tag  <= tag_q;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_isqrt_exec_unit.sv
// Bench for isqrt_exec_unit: directed and random radicands on a 32-bit/1-step
// unit and a 16-bit/2-step unit, checked against a multiply-based floor sqrt.
module tb_isqrt_exec_unit;

  localparam int NA = 16;
  localparam int NB = 4;

  logic        clk1 = 1'b0;
  logic        rst, flush;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_radicand;
  logic [4:0]  in_tag, out_tag;
  logic [15:0] out_root;
  logic [16:0] out_rem;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [15:0] b_in_radicand;
  logic [4:0]  b_in_tag, b_out_tag;
  logic [7:0]  b_out_root;
  logic [8:0]  b_out_rem;

  int errors = 0;
  int checks = 0;

  always #5 clk1 = ~clk1;

  isqrt_exec_unit #(.DATA_W(32), .TAG_W(5), .ITER_PER_CYC(1)) dut_a (
    .clk1(clk1), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_radicand(in_radicand), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_root(out_root), .out_rem(out_rem),
    .out_tag(out_tag), .busy(busy)
  );

  isqrt_exec_unit #(.DATA_W(16), .TAG_W(5), .ITER_PER_CYC(2)) dut_b (
    .clk1(clk1), .rst(rst), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_radicand(b_in_radicand), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_root(b_out_root), .out_rem(b_out_rem),
    .out_tag(b_out_tag), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Largest r with r*r <= x, found by setting root bits high to low.
  function automatic longint unsigned ref_root(input longint unsigned x);
    longint unsigned r = 0;
    longint unsigned c;
    for (int b = 31; b >= 0; b--) begin
      c = r | (64'd1 << b);
      if (c * c <= x) r = c;
    end
    return r;
  endfunction

  task automatic step();
    @(negedge clk1);
  endtask

  task automatic start_a(input logic [31:0] rad, input logic [4:0] tag);
    int w = 0;
    int lat = 0;
    bit busy_bad = 0;
    longint unsigned r;
    while (!in_ready && w < 100) begin
      step();
      w++;
    end
    check("a_ready_wait", in_ready, 1);
    in_valid = 1; in_radicand = rad; in_tag = tag;
    step();
    in_valid = 0;
    while (!out_valid && lat < 100) begin
      if (!busy) busy_bad = 1;
      in_radicand = $urandom;
      step();
      lat++;
    end
    if (!busy) busy_bad = 1;
    check("a_latency", lat, NA);
    check("a_busy", busy_bad, 0);
    r = ref_root(64'(rad));
    check("a_root", out_root, r);
    check("a_rem", out_rem, 64'(rad) - r * r);
    check("a_tag", out_tag, tag);
  endtask

  task automatic drain_a(input int stall);
    bit hold_bad = 0;
    logic [15:0] r0;
    logic [16:0] m0;
    logic [4:0]  t0;
    r0 = out_root; m0 = out_rem; t0 = out_tag;
    out_ready = 0;
    repeat (stall) begin
      step();
      if (!out_valid || out_root !== r0 || out_rem !== m0 || out_tag !== t0) hold_bad = 1;
    end
    check("a_stall_hold", hold_bad, 0);
    out_ready = 1;
    step();
    out_ready = 0;
    check("a_valid_drop", out_valid, 0);
    check("a_ready_after", in_ready, 1);
  endtask

  task automatic run_b(input logic [15:0] rad);
    int lat = 0;
    longint unsigned r;
    check("b_ready", b_in_ready, 1);
    b_in_valid = 1; b_in_radicand = rad; b_in_tag = rad[4:0];
    step();
    b_in_valid = 0;
    while (!b_out_valid && lat < 50) begin
      step();
      lat++;
    end
    check("b_latency", lat, NB);
    r = ref_root(64'(rad));
    check("b_root", b_out_root, r);
    check("b_rem", b_out_rem, 64'(rad) - r * r);
    check("b_tag", b_out_tag, rad[4:0]);
    b_out_ready = 1;
    step();
    b_out_ready = 0;
    check("b_valid_drop", b_out_valid, 0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_root"}, out_root, 0);
    check({tag, "_rem"}, out_rem, 0);
    check({tag, "_tag"}, out_tag, 0);
    check({tag, "_ready"}, in_ready, 1);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    logic [31:0] rad;
    int k;
    bit rose;
    rst = 1; flush = 0;
    in_valid = 0; in_radicand = 0; in_tag = 0; out_ready = 0;
    b_in_valid = 0; b_in_radicand = 0; b_in_tag = 0; b_out_ready = 0;
    repeat (3) step();
    rst = 0;
    check_cleared("reset");
    check("b_reset_valid", b_out_valid, 0);

    start_a(32'd144, 5'd3);
    drain_a(0);

    start_a(32'd200, 5'd7);
    in_valid = 1; in_radicand = 32'd0; in_tag = 5'd9;
    drain_a(2);
    check("no_accept_in_done", busy, 0);
    start_a(32'd0, 5'd9);
    drain_a(0);

    start_a(32'hFFFF_FFFF, 5'd1);
    check("max_root", out_root, 65535);
    check("max_rem", out_rem, 131070);
    drain_a(5);

    in_valid = 1; in_radicand = 32'd1000; in_tag = 5'd4;
    step();
    in_valid = 0;
    repeat (6) step();
    flush = 1;
    step();
    flush = 0;
    check("flush_ready", in_ready, 1);
    check("flush_valid", out_valid, 0);
    check("flush_busy", busy, 0);
    rose = 0;
    repeat (25) begin
      step();
      if (out_valid) rose = 1;
    end
    check("flush_no_result", rose, 0);
    start_a(32'd1000, 5'd4);
    check("r1000_root", out_root, 31);
    check("r1000_rem", out_rem, 39);
    drain_a(1);

    flush = 1; in_valid = 1; in_radicand = 32'd50;
    step();
    flush = 0; in_valid = 0;
    check("flush_idle_ready", in_ready, 1);
    check("flush_idle_busy", busy, 0);

    in_valid = 1; in_radicand = 32'd12345; in_tag = 5'd21;
    step();
    in_valid = 0;
    repeat (5) step();
    rst = 1;
    step();
    rst = 0;
    check_cleared("rst_calc");

    start_a(32'd99, 5'd2);
    rst = 1; flush = 1;
    step();
    rst = 0; flush = 0;
    check_cleared("rst_flush_done");

    for (int i = 0; i < 24; i++) begin
      k = $urandom_range(0, 3);
      case (k)
        0: rad = $urandom;
        1: rad = $urandom_range(0, 1023);
        2: begin rad = $urandom_range(0, 65535); rad = rad * rad; end
        default: begin rad = $urandom_range(1, 65535); rad = rad * rad - 1; end
      endcase
      start_a(rad, 5'($urandom_range(0, 31)));
      drain_a($urandom_range(0, 3));
    end

    run_b(16'hFFFF);
    check("b_max_root", b_out_root, 255);
    check("b_max_rem", b_out_rem, 510);
    for (int i = 0; i < 6; i++) run_b(16'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
